approx_seq_div_signed: RTL and testbench



---
 rtl/approx_div_pkg.sv | 34 +++
 rtl/approx_div_lzc.sv | 26 ++
 rtl/approx_seq_div_signed.sv | 189 ++++++++++++++++++
 tb/tb_approx_seq_div_signed.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_div_pkg.sv
// approx_div_pkg
// Shared definitions for the approximate signed divider:
//   - FSM state encoding
//   - default operand widths and approximate iteration count
//   - iteration counter width helper
//   - divide-by-zero saturation values
// No ports (package).
package approx_div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ITER  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int DIVIDEND_W_DEF   = 32;
    localparam int DIVISOR_W_DEF    = 16;
    localparam int APPROX_ITERS_DEF = 24;

    // Counter must be able to hold the full iteration count DIVIDEND_W.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    // Saturated quotient for a zero divisor, returned 64 bits wide; callers
    // keep the low w bits. Positive: 2^(w-1)-1, negative: -2^(w-1).
    function automatic logic [63:0] div0_quot(input int w, input logic neg);
        logic [63:0] max_pos;
        max_pos = (64'd1 << (w - 1)) - 64'd1;
        return neg ? ~max_pos : max_pos;
    endfunction

endpackage

// File: rtl/approx_div_lzc.sv
// approx_div_lzc
// Parameterised leading-zero counter used to skip the zero quotient MSBs.
// Only compiled when APPROX_DIV_EARLY_TERM_EN is defined, so the default
// build carries no leading-zero logic at all.
// Ports:
//   a_i   [W-1:0]   operand
//   cnt_o [CW-1:0]  number of leading zeros (W when a_i == 0)
`ifdef APPROX_DIV_EARLY_TERM_EN
module approx_div_lzc #(
    parameter  int W  = 32,
    localparam int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  a_i,
    output logic [CW-1:0] cnt_o
);

    // Ascending scan: the last hit is the highest set bit.
    always_comb begin
        cnt_o = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (a_i[i]) cnt_o = CW'(W - 1 - i);
        end
    end

endmodule
`endif

// File: rtl/approx_seq_div_signed.sv
// approx_seq_div_signed
// Iterative radix-2 restoring signed divider with precise/approximate mode.
// One quotient bit per enabled cycle; approximate mode evaluates only the top
// APPROX_ITERS quotient bits and reports a zero remainder.
// Optional build macro: APPROX_DIV_EARLY_TERM_EN -- skips leading zero
// quotient bits using a leading-zero count of |dividend| (latency only).
// Ports:
//   clk, rst (sync, active-low), clk_en (freezes everything when low)
//   in_valid/in_ready, dividend[DIVIDEND_W], divisor[DIVISOR_W], precise_en
//   out_valid/out_ready, quotient[DIVIDEND_W], remainder[DIVISOR_W],
//   div_by_zero
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// ITER  | one restoring step per enabled cycle
// FIXUP | apply signs / saturation, register outputs
// DONE  | result held until out_ready
module approx_seq_div_signed
    import approx_div_pkg::*;
#(
    parameter int DIVIDEND_W   = DIVIDEND_W_DEF,
    parameter int DIVISOR_W    = DIVISOR_W_DEF,
    parameter int APPROX_ITERS = APPROX_ITERS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    input  logic                  precise_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int          CNT_W    = cnt_width(DIVIDEND_W);
    localparam int          SKIP     = DIVIDEND_W - APPROX_ITERS;
    localparam logic [63:0] DIV0_POS = div0_quot(DIVIDEND_W, 1'b0);
    localparam logic [63:0] DIV0_NEG = div0_quot(DIVIDEND_W, 1'b1);

    state_e                  state_q;
    logic                    sgn_dvd_q, sgn_dsr_q, precise_q, zero_q;
    logic [DIVIDEND_W-1:0]   dvd_q, quo_q;
    logic [DIVISOR_W-1:0]    dsr_q, rem_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [DIVIDEND_W-1:0]   quotient_q;
    logic [DIVISOR_W-1:0]    remainder_q;
    logic                    out_valid_q, div_by_zero_q;

    // Magnitudes; -2^(W-1) maps onto 2^(W-1), which fits unsigned.
    logic [DIVIDEND_W-1:0] dvd_abs;
    logic [DIVISOR_W-1:0]  dsr_abs;
    assign dvd_abs = dividend[DIVIDEND_W-1] ? -dividend : dividend;
    assign dsr_abs = divisor[DIVISOR_W-1]   ? -divisor  : divisor;

    logic [CNT_W-1:0]      n_load;
    logic [DIVIDEND_W-1:0] dvd_load;
    logic                  zero_load;

`ifdef APPROX_DIV_EARLY_TERM_EN
    logic [CNT_W-1:0] lz, sig;

    approx_div_lzc #(.W(DIVIDEND_W)) u_lzc (
        .a_i   (dvd_abs),
        .cnt_o (lz)
    );

    assign sig = CNT_W'(DIVIDEND_W) - lz;

    // zero_load marks approximate ops whose significant bits all fall in
    // the unevaluated LSBs: one dummy step runs, the quotient is forced 0.
    always_comb begin
        dvd_load  = dvd_abs << lz;
        zero_load = 1'b0;
        if (precise_en) begin
            n_load = (sig == '0) ? CNT_W'(1) : sig;
        end else if (sig > CNT_W'(SKIP)) begin
            n_load = sig - CNT_W'(SKIP);
        end else begin
            n_load    = CNT_W'(1);
            zero_load = 1'b1;
        end
    end
`else
    assign dvd_load  = dvd_abs;
    assign zero_load = 1'b0;
    assign n_load    = precise_en ? CNT_W'(DIVIDEND_W) : CNT_W'(APPROX_ITERS);
`endif

    // Restoring step: the partial remainder is one bit wider than the divisor.
    logic [DIVISOR_W:0]    trial;
    logic                  trial_ge;
    logic [DIVISOR_W-1:0]  rem_d;
    logic [DIVIDEND_W-1:0] quo_d;

    assign trial    = {rem_q, dvd_q[DIVIDEND_W-1]};
    assign trial_ge = trial >= {1'b0, dsr_q};
    assign rem_d    = trial_ge ? DIVISOR_W'(trial - {1'b0, dsr_q})
                               : trial[DIVISOR_W-1:0];
    assign quo_d    = {quo_q[DIVIDEND_W-2:0], trial_ge};

    // In approximate mode the computed bits sit in the LSBs and are moved up
    // to their true weight here.
    logic [DIVIDEND_W-1:0] quo_mag, quo_fix;
    logic [DIVISOR_W-1:0]  rem_fix;

    always_comb begin
        quo_mag = quo_q;
        if (!precise_q) quo_mag = zero_q ? '0 : (quo_q << SKIP);
        quo_fix = (sgn_dvd_q ^ sgn_dsr_q) ? -quo_mag : quo_mag;
        rem_fix = '0;
        if (precise_q) rem_fix = sgn_dvd_q ? -rem_q : rem_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            sgn_dvd_q     <= 1'b0;
            sgn_dsr_q     <= 1'b0;
            precise_q     <= 1'b0;
            zero_q        <= 1'b0;
            dvd_q         <= '0;
            quo_q         <= '0;
            dsr_q         <= '0;
            rem_q         <= '0;
            cnt_q         <= '0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            out_valid_q   <= 1'b0;
            div_by_zero_q <= 1'b0;
        end else if (clk_en) begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sgn_dvd_q <= dividend[DIVIDEND_W-1];
                        sgn_dsr_q <= divisor[DIVISOR_W-1];
                        dvd_q     <= dvd_load;
                        dsr_q     <= dsr_abs;
                        rem_q     <= '0;
                        quo_q     <= '0;
                        cnt_q     <= n_load;
                        precise_q <= precise_en;
                        zero_q    <= zero_load;
                        state_q   <= (dsr_abs == '0) ? FIXUP : ITER;
                    end
                end
                ITER: begin
                    dvd_q <= dvd_q << 1;
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    if (cnt_q == CNT_W'(1)) state_q <= FIXUP;
                    else                    cnt_q   <= cnt_q - CNT_W'(1);
                end
                FIXUP: begin
                    if (dsr_q == '0) begin
                        quotient_q    <= sgn_dvd_q ? DIV0_NEG[DIVIDEND_W-1:0]
                                                   : DIV0_POS[DIVIDEND_W-1:0];
                        remainder_q   <= '0;
                        div_by_zero_q <= 1'b1;
                    end else begin
                        quotient_q    <= quo_fix;
                        remainder_q   <= rem_fix;
                        div_by_zero_q <= 1'b0;
                    end
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_approx_seq_div_signed.sv
// Testbench for approx_seq_div_signed: directed + random operands, a
// scoreboard queue filled at accept time and drained by a monitor process.
module tb_approx_seq_div_signed;

    localparam int W  = 32;
    localparam int DW = 16;
    localparam int A  = 24;

    logic          clk = 1'b0;
    logic          rst, clk_en, in_valid, in_ready, precise_en;
    logic          out_valid, out_ready, div_by_zero;
    logic [W-1:0]  dividend, quotient;
    logic [DW-1:0] divisor, remainder;

    approx_seq_div_signed #(.DIVIDEND_W(W), .DIVISOR_W(DW), .APPROX_ITERS(A)) dut (
        .clk         (clk),
        .rst         (rst),
        .clk_en      (clk_en),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .precise_en  (precise_en),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [W-1:0]  q;
        logic [DW-1:0] r;
        logic          dz;
        int            lat;
        int            acc;
        int            bp;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sig_bits(input longint m);
        int s = 0;
        while (m != 0) begin
            s++;
            m = m >> 1;
        end
        return s;
    endfunction

    // Reference: plain integer division on magnitudes, then signs.
    function automatic exp_t model(input logic [W-1:0] d, input logic [DW-1:0] v,
                                   input bit p, input int stall);
        exp_t   e;
        longint a, b, am, bm, qm, rm, qs, rs;
        int     n;
        a = $signed(d);
        b = $signed(v);
        e.bp  = 0;
        e.acc = 0;
        if (b == 0) begin
            e.q   = (a >= 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
            e.r   = '0;
            e.dz  = 1'b1;
            e.lat = 2 + stall;
            return e;
        end
        am = (a < 0) ? -a : a;
        bm = (b < 0) ? -b : b;
        qm = am / bm;
        rm = am % bm;
        if (!p) begin
            qm = (qm >> (W - A)) << (W - A);
            rm = 0;
        end
        qs = ((a < 0) != (b < 0)) ? -qm : qm;
        rs = (a < 0) ? -rm : rm;
        e.q  = qs[W-1:0];
        e.r  = rs[DW-1:0];
        e.dz = 1'b0;
`ifdef APPROX_DIV_EARLY_TERM_EN
        n = p ? sig_bits(am) : sig_bits(am) - (W - A);
        if (n < 1) n = 1;
`else
        n = p ? W : A;
`endif
        e.lat = n + 2 + stall;
        return e;
    endfunction

    task automatic issue(input logic [W-1:0] d, input logic [DW-1:0] v, input bit p,
                         input int bp, input int stall, input bit push);
        exp_t e;
        int   waited = 0;
        e    = model(d, v, p, stall);
        e.bp = bp;
        @(negedge clk);
        while (!in_ready && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            chk("in_ready_wait", in_ready, 1);
            return;
        end
        dividend   = d;
        divisor    = v;
        precise_en = p;
        in_valid   = 1'b1;
        @(negedge clk);
        in_valid   = 1'b0;
        dividend   = $urandom;
        divisor    = DW'($urandom);
        precise_en = 1'($urandom);
        e.acc = edge_cnt;
        if (push) sb.push_back(e);
        if (stall > 0) begin
            repeat (3) @(negedge clk);
            clk_en = 1'b0;
            repeat (stall) begin
                @(negedge clk);
                chk("stall_in_ready", in_ready, 0);
            end
            clk_en = 1'b1;
        end
    endtask

    // Monitor: pops one expectation per result, applies backpressure, checks
    // hold stability and the release handshake.
    initial begin
        exp_t e;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", out_valid, 0);
                    out_ready = 1'b1;
                    @(negedge clk);
                    out_ready = 1'b0;
                end else begin
                    e = sb.pop_front();
                    chk("latency", edge_cnt - e.acc + 1, e.lat);
                    chk("quotient", quotient, e.q);
                    chk("remainder", remainder, e.r);
                    chk("div_by_zero", div_by_zero, e.dz);
                    chk("busy_in_ready", in_ready, 0);
                    repeat (e.bp) begin
                        @(negedge clk);
                        chk("hold_valid", out_valid, 1);
                        chk("hold_quotient", quotient, e.q);
                        chk("hold_remainder", remainder, e.r);
                        chk("hold_in_ready", in_ready, 0);
                    end
                    out_ready = 1'b1;
                    @(negedge clk);
                    out_ready = 1'b0;
                    chk("release_valid", out_valid, 0);
                    chk("release_in_ready", in_ready, 1);
                end
            end
        end
    end

    initial begin
        #500000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        logic [W-1:0]  d;
        logic [DW-1:0] v;
        bit            p;
        int            t;

        rst        = 1'b0;
        clk_en     = 1'b1;
        in_valid   = 1'b0;
        dividend   = '0;
        divisor    = '0;
        precise_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_div_by_zero", div_by_zero, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b1;

        issue(32'd100, 16'd7, 1'b1, 0, 0, 1'b1);
        issue(-32'sd100, 16'd7, 1'b1, 0, 0, 1'b1);
        issue(32'd100, -16'sd7, 1'b1, 0, 0, 1'b1);
        issue(-32'sd100, -16'sd7, 1'b1, 0, 0, 1'b1);
        issue(32'd1000000, 16'd3, 1'b0, 0, 0, 1'b1);
        issue(32'd5, 16'd0, 1'b1, 0, 0, 1'b1);
        issue(-32'sd5, 16'd0, 1'b0, 0, 0, 1'b1);
        issue(32'h8000_0000, 16'hFFFF, 1'b1, 0, 0, 1'b1);
        issue(32'h8000_0000, 16'h8000, 1'b1, 0, 0, 1'b1);
        issue(32'h7FFF_FFFF, 16'h7FFF, 1'b0, 0, 0, 1'b1);
        issue(32'd0, 16'd9, 1'b0, 0, 0, 1'b1);
        issue(32'd200, 16'd3, 1'b0, 0, 0, 1'b1);

        // Backpressure, then a clk_en gap in ITER.
        issue(32'd987654, -16'sd321, 1'b1, 5, 0, 1'b1);
        issue(32'd123456789, 16'd1234, 1'b1, 0, 3, 1'b1);

        // Reset at edge 10 of a long division: no result may appear.
        issue(32'h7FFF_0000, 16'd3, 1'b1, 0, 0, 1'b0);
        repeat (8) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_quotient", quotient, 0);
        chk("midrst_in_ready", in_ready, 1);
        rst = 1'b1;
        issue(32'd8, 16'd2, 1'b1, 0, 0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0:       d = $urandom;
                1:       d = W'($urandom_range(0, 5000));
                default: d = -W'($urandom_range(0, 5000));
            endcase
            case ($urandom_range(0, 4))
                0:       v = DW'($urandom_range(1, 15));
                1:       v = -DW'($urandom_range(1, 15));
                2:       v = 16'd0;
                default: v = DW'($urandom);
            endcase
            p = 1'($urandom);
            issue(d, v, p, $urandom_range(0, 2), 0, 1'b1);
        end

        t = 0;
        while ((sb.size() != 0 || out_valid) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("drain", sb.size(), 0);
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
